// File: rtl/vx_smem_ext_adapter.sv
// Per-lane adapter from the core shared-memory channel to an SRAM-style external port.
// One registered request slot, an in-order tag FIFO, and a response FIFO for returning reads.
module vx_smem_ext_adapter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int EXT_ADDR_WIDTH = 12,
  parameter int DATA_SIZE      = 4,
  parameter int TAG_WIDTH      = 8,
  parameter int MAX_PENDING    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_req_valid,
  input  logic                         core_req_rw,
  input  logic [ADDR_WIDTH-1:0]        core_req_addr,
  input  logic [DATA_SIZE-1:0]         core_req_byteen,
  input  logic [DATA_SIZE*8-1:0]       core_req_data,
  input  logic [TAG_WIDTH-1:0]         core_req_tag,
  output logic                         core_req_ready,
  output logic                         core_rsp_valid,
  output logic [DATA_SIZE*8-1:0]       core_rsp_data,
  output logic [TAG_WIDTH-1:0]         core_rsp_tag,
  input  logic                         core_rsp_ready,
  output logic                         mem_req_valid,
  output logic                         mem_req_rw,
  output logic [EXT_ADDR_WIDTH-1:0]    mem_req_addr,
  output logic [DATA_SIZE-1:0]         mem_req_byteen,
  output logic [DATA_SIZE*8-1:0]       mem_req_data,
  input  logic                         mem_req_ready,
  input  logic                         mem_rsp_valid,
  input  logic [DATA_SIZE*8-1:0]       mem_rsp_data,
  output logic [$clog2(MAX_PENDING):0] pending_count,
  output logic                         err_unexpected_rsp,
  output logic                         err_addr_range
);

  localparam int DATA_WIDTH = DATA_SIZE * 8;
  localparam int PW         = $clog2(MAX_PENDING);
  localparam int CW         = PW + 1;

  logic                  req_full;
  logic                  accept;
  logic                  read_accept;
  logic                  tag_empty;
  logic                  rsp_empty;
  logic                  rsp_push;
  logic                  rsp_pop;
  logic                  addr_high;
  logic [CW-1:0]         tag_wr;
  logic [CW-1:0]         tag_rd;
  logic [CW-1:0]         rsp_wr;
  logic [CW-1:0]         rsp_rd;
  logic [CW-1:0]         pending_q;
  logic [TAG_WIDTH-1:0]  tag_mem      [MAX_PENDING];
  logic [DATA_WIDTH-1:0] rsp_data_mem [MAX_PENDING];
  logic [TAG_WIDTH-1:0]  rsp_tag_mem  [MAX_PENDING];

  // Reads need a credit so the response FIFO can always absorb unstoppable mem responses.
  assign core_req_ready = reset && (!req_full || mem_req_ready) &&
                          (core_req_rw || (pending_q < CW'(MAX_PENDING)));
  assign accept         = core_req_valid && core_req_ready;
  assign read_accept    = accept && !core_req_rw;
  assign addr_high      = |core_req_addr[ADDR_WIDTH-1:EXT_ADDR_WIDTH];

  assign tag_empty      = (tag_wr == tag_rd);
  assign rsp_empty      = (rsp_wr == rsp_rd);
  assign rsp_push       = mem_rsp_valid && !tag_empty;
  assign rsp_pop        = !rsp_empty && core_rsp_ready;

  assign mem_req_valid  = req_full;
  assign core_rsp_valid = !rsp_empty;
  assign core_rsp_data  = rsp_data_mem[rsp_rd[PW-1:0]];
  assign core_rsp_tag   = rsp_tag_mem[rsp_rd[PW-1:0]];
  assign pending_count  = pending_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_full       <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_byteen <= '0;
      mem_req_data   <= '0;
    end else if (accept) begin
      req_full       <= 1'b1;
      mem_req_rw     <= core_req_rw;
      mem_req_addr   <= core_req_addr[EXT_ADDR_WIDTH-1:0];
      mem_req_byteen <= core_req_byteen;
      mem_req_data   <= core_req_data;
    end else if (mem_req_ready) begin
      req_full       <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_wr <= '0;
      tag_rd <= '0;
      for (int i = 0; i < MAX_PENDING; i++) tag_mem[i] <= '0;
    end else begin
      if (read_accept) begin
        tag_mem[tag_wr[PW-1:0]] <= core_req_tag;
        tag_wr                  <= tag_wr + CW'(1);
      end
      if (rsp_push) tag_rd <= tag_rd + CW'(1);
    end
  end

  // Response data is stored before it is presented, so valid appears one cycle after mem_rsp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_wr <= '0;
      rsp_rd <= '0;
      for (int i = 0; i < MAX_PENDING; i++) begin
        rsp_data_mem[i] <= '0;
        rsp_tag_mem[i]  <= '0;
      end
    end else begin
      if (rsp_push) begin
        rsp_data_mem[rsp_wr[PW-1:0]] <= mem_rsp_data;
        rsp_tag_mem[rsp_wr[PW-1:0]]  <= tag_mem[tag_rd[PW-1:0]];
        rsp_wr                       <= rsp_wr + CW'(1);
      end
      if (rsp_pop) rsp_rd <= rsp_rd + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q          <= '0;
      err_unexpected_rsp <= 1'b0;
      err_addr_range     <= 1'b0;
    end else begin
      case ({read_accept, rsp_pop})
        2'b10:   pending_q <= pending_q + CW'(1);
        2'b01:   pending_q <= pending_q - CW'(1);
        default: pending_q <= pending_q;
      endcase
      if (mem_rsp_valid && tag_empty) err_unexpected_rsp <= 1'b1;
      if (accept && addr_high)        err_addr_range     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_smem_ext_adapter.sv
// Scoreboard bench for vx_smem_ext_adapter: stimulus pushes expected mem requests and core
// responses into queues, and a negedge monitor pops and compares them on every handshake.
module tb_vx_smem_ext_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req_valid;
  logic        core_req_rw;
  logic [31:0] core_req_addr;
  logic [3:0]  core_req_byteen;
  logic [31:0] core_req_data;
  logic [7:0]  core_req_tag;
  logic        core_req_ready;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_data;
  logic [7:0]  core_rsp_tag;
  logic        core_rsp_ready;
  logic        mem_req_valid;
  logic        mem_req_rw;
  logic [11:0] mem_req_addr;
  logic [3:0]  mem_req_byteen;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [2:0]  pending_count;
  logic        err_unexpected_rsp;
  logic        err_addr_range;

  typedef struct packed {
    logic        rw;
    logic [11:0] addr;
    logic [3:0]  byteen;
    logic [31:0] data;
  } mreq_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tag;
  } rsp_t;

  mreq_t mem_q[$];
  rsp_t  rsp_q[$];
  mreq_t mon_m;
  rsp_t  mon_r;
  int    tests  = 0;
  int    errors = 0;

  vx_smem_ext_adapter dut (
    .clk                (clk),
    .reset              (reset),
    .core_req_valid     (core_req_valid),
    .core_req_rw        (core_req_rw),
    .core_req_addr      (core_req_addr),
    .core_req_byteen    (core_req_byteen),
    .core_req_data      (core_req_data),
    .core_req_tag       (core_req_tag),
    .core_req_ready     (core_req_ready),
    .core_rsp_valid     (core_rsp_valid),
    .core_rsp_data      (core_rsp_data),
    .core_rsp_tag       (core_rsp_tag),
    .core_rsp_ready     (core_rsp_ready),
    .mem_req_valid      (mem_req_valid),
    .mem_req_rw         (mem_req_rw),
    .mem_req_addr       (mem_req_addr),
    .mem_req_byteen     (mem_req_byteen),
    .mem_req_data       (mem_req_data),
    .mem_req_ready      (mem_req_ready),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_data       (mem_rsp_data),
    .pending_count      (pending_count),
    .err_unexpected_rsp (err_unexpected_rsp),
    .err_addr_range     (err_addr_range)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts and ends at posedge+1; holds the request until it is accepted or the budget expires.
  task automatic apply_stimulus(input logic rw, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] data, input logic [7:0] tag);
    int n = 0;
    core_req_valid  = 1'b1;
    core_req_rw     = rw;
    core_req_addr   = addr;
    core_req_byteen = be;
    core_req_data   = data;
    core_req_tag    = tag;
    @(negedge clk);
    while (!core_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!core_req_ready) begin
      check_output("req_accept_timeout", 64'(core_req_ready), 64'd1);
    end else begin
      mem_q.push_back('{rw: rw, addr: addr[11:0], byteen: be, data: data});
    end
    @(posedge clk);
    #1;
    core_req_valid = 1'b0;
  endtask

  task automatic mem_pulse(input logic [31:0] data, input logic [7:0] tag, input logic expect_rsp);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    if (expect_rsp) rsp_q.push_back('{data: data, tag: tag});
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_req_valid && mem_req_ready) begin
        if (mem_q.size() == 0) begin
          tests++;
          errors++;
          $display("[TB] FAIL mem_req_extra: got addr %0h expected no request", mem_req_addr);
        end else begin
          mon_m = mem_q.pop_front();
          check_output("mem_req_rw", 64'(mem_req_rw), 64'(mon_m.rw));
          check_output("mem_req_addr", 64'(mem_req_addr), 64'(mon_m.addr));
          if (mon_m.rw) begin
            check_output("mem_req_byteen", 64'(mem_req_byteen), 64'(mon_m.byteen));
            check_output("mem_req_data", 64'(mem_req_data), 64'(mon_m.data));
          end
        end
      end
      if (core_rsp_valid && core_rsp_ready) begin
        if (rsp_q.size() == 0) begin
          tests++;
          errors++;
          $display("[TB] FAIL core_rsp_extra: got tag %0h expected no response", core_rsp_tag);
        end else begin
          mon_r = rsp_q.pop_front();
          check_output("core_rsp_data", 64'(core_rsp_data), 64'(mon_r.data));
          check_output("core_rsp_tag", 64'(core_rsp_tag), 64'(mon_r.tag));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b0;
    core_req_valid  = 1'b0;
    core_req_rw     = 1'b0;
    core_req_addr   = '0;
    core_req_byteen = '0;
    core_req_data   = '0;
    core_req_tag    = '0;
    core_rsp_ready  = 1'b0;
    mem_req_ready   = 1'b1;
    mem_rsp_valid   = 1'b0;
    mem_rsp_data    = '0;

    @(negedge clk);
    check_output("reset_core_req_ready", 64'(core_req_ready), 64'd0);
    check_output("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_output("reset_core_rsp_valid", 64'(core_rsp_valid), 64'd0);
    check_output("reset_pending", 64'(pending_count), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_cycles(1);

    // Single read with response latency check.
    apply_stimulus(1'b0, 32'h10, 4'hF, 32'h0, 8'h5A);
    @(negedge clk);
    check_output("t1_pending_after_accept", 64'(pending_count), 64'd1);
    wait_cycles(1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEADBEEF;
    rsp_q.push_back('{data: 32'hDEADBEEF, tag: 8'h5A});
    @(negedge clk);
    check_output("t1_rsp_valid_cycle_m", 64'(core_rsp_valid), 64'd0);
    @(posedge clk);
    #1 mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_output("t1_rsp_valid_cycle_m1", 64'(core_rsp_valid), 64'd1);
    check_output("t1_pending_before_pop", 64'(pending_count), 64'd1);
    @(posedge clk);
    #1 core_rsp_ready = 1'b1;
    wait_cycles(1);
    @(negedge clk);
    check_output("t1_pending_after_pop", 64'(pending_count), 64'd0);
    check_output("t1_rsp_valid_after_pop", 64'(core_rsp_valid), 64'd0);

    // Fill credits, stall a fifth read, let a write through, then drain in order.
    @(posedge clk);
    #1 core_rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) apply_stimulus(1'b0, 32'h20 + 32'(i), 4'hF, 32'h0, 8'(i));
    @(negedge clk);
    check_output("t2_pending_full", 64'(pending_count), 64'd4);
    @(posedge clk);
    #1;
    core_req_valid = 1'b1;
    core_req_rw    = 1'b0;
    core_req_addr  = 32'h50;
    core_req_tag   = 8'h05;
    @(negedge clk);
    check_output("t2_read_stalled", 64'(core_req_ready), 64'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 32'h40, 4'hC, 32'hCAFE0000, 8'h00);
    for (int i = 1; i <= 4; i++) mem_pulse(32'hA0000000 + 32'(i), 8'(i), 1'b1);
    @(negedge clk);
    check_output("t2_pending_rsp_buffered", 64'(pending_count), 64'd4);
    check_output("t2_head_tag", 64'(core_rsp_tag), 64'd1);
    @(posedge clk);
    #1;
    fork
      apply_stimulus(1'b0, 32'h50, 4'hF, 32'h0, 8'h05);
      core_rsp_ready = 1'b1;
    join
    wait_cycles(6);
    @(negedge clk);
    check_output("t2_pending_after_drain", 64'(pending_count), 64'd1);
    @(posedge clk);
    #1;
    mem_pulse(32'h55555555, 8'h05, 1'b1);
    wait_cycles(3);
    @(negedge clk);
    check_output("t2_pending_final", 64'(pending_count), 64'd0);

    // External port stalled for three cycles.
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    apply_stimulus(1'b1, 32'h60, 4'hF, 32'h11112222, 8'h00);
    fork
      apply_stimulus(1'b1, 32'h61, 4'h5, 32'h33334444, 8'h00);
      begin
        repeat (3) begin
          @(negedge clk);
          check_output("t3_stall_valid", 64'(mem_req_valid), 64'd1);
          check_output("t3_stall_addr", 64'(mem_req_addr), 64'h060);
          check_output("t3_stall_data", 64'(mem_req_data), 64'h11112222);
          check_output("t3_stall_ready", 64'(core_req_ready), 64'd0);
        end
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
      end
    join
    wait_cycles(3);
    check_output("t3_mem_queue_empty", 64'(mem_q.size()), 64'd0);

    // Partial-byte write: forwarded, never answered.
    apply_stimulus(1'b1, 32'h33, 4'b0011, 32'h1234ABCD, 8'h00);
    wait_cycles(3);
    @(negedge clk);
    check_output("t4_pending", 64'(pending_count), 64'd0);
    check_output("t4_no_rsp", 64'(core_rsp_valid), 64'd0);
    check_output("t4_no_err_before", 64'(err_unexpected_rsp), 64'd0);

    // Response with nothing outstanding.
    @(posedge clk);
    #1;
    mem_pulse(32'h00000BAD, 8'h00, 1'b0);
    @(negedge clk);
    check_output("t5_err_unexpected", 64'(err_unexpected_rsp), 64'd1);
    wait_cycles(3);
    @(negedge clk);
    check_output("t5_err_sticky", 64'(err_unexpected_rsp), 64'd1);
    check_output("t5_no_rsp", 64'(core_rsp_valid), 64'd0);
    check_output("t5_addr_err_clear", 64'(err_addr_range), 64'd0);

    // Out-of-range address, then reset with two reads pending.
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 32'h1000, 4'hF, 32'h0, 8'h77);
    @(negedge clk);
    check_output("t6_err_addr_range", 64'(err_addr_range), 64'd1);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 32'h2, 4'hF, 32'h0, 8'h78);
    wait_cycles(1);
    @(negedge clk);
    check_output("t6_pending_two", 64'(pending_count), 64'd2);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("t6_rst_core_req_ready", 64'(core_req_ready), 64'd0);
    check_output("t6_rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_output("t6_rst_mem_req_rw", 64'(mem_req_rw), 64'd0);
    check_output("t6_rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    check_output("t6_rst_mem_req_byteen", 64'(mem_req_byteen), 64'd0);
    check_output("t6_rst_mem_req_data", 64'(mem_req_data), 64'd0);
    check_output("t6_rst_core_rsp_valid", 64'(core_rsp_valid), 64'd0);
    check_output("t6_rst_core_rsp_data", 64'(core_rsp_data), 64'd0);
    check_output("t6_rst_core_rsp_tag", 64'(core_rsp_tag), 64'd0);
    check_output("t6_rst_pending", 64'(pending_count), 64'd0);
    check_output("t6_rst_err_unexpected", 64'(err_unexpected_rsp), 64'd0);
    check_output("t6_rst_err_addr", 64'(err_addr_range), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_cycles(1);
    mem_pulse(32'h0BADF00D, 8'h00, 1'b0);
    @(negedge clk);
    check_output("t6_late_rsp_err", 64'(err_unexpected_rsp), 64'd1);
    check_output("t6_late_rsp_no_valid", 64'(core_rsp_valid), 64'd0);

    wait_cycles(3);
    check_output("end_mem_queue_empty", 64'(mem_q.size()), 64'd0);
    check_output("end_rsp_queue_empty", 64'(rsp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/vx_smem_ext_adapter.md
Name: vx_smem_ext_adapter

Overview:
Per-lane adapter that consumes the external shared-memory request/response channel driven by the core's smem switch output when external shared memory is selected. It registers core requests onto a simple SRAM-style external port (ready/valid request, fixed-order, no-backpressure response) and tracks outstanding read tags in order. It buffers returning read data and presents it back to the core channel with ready/valid flow control. One instance per DCACHE request lane.

Parameters:
ADDR_WIDTH, 32, word address width on the core side
EXT_ADDR_WIDTH, 12, word address width on the external port; low bits of the core address
DATA_SIZE, 4, bytes per word
TAG_WIDTH, 8, core request/response tag width
MAX_PENDING, 4, maximum outstanding reads (tag FIFO and response FIFO depth); power of 2, ≥2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
core_req_valid  in  1  core request valid
core_req_rw  in  1  1=write, 0=read
core_req_addr  in  ADDR_WIDTH  word address
core_req_byteen  in  DATA_SIZE  byte enables (writes)
core_req_data  in  DATA_SIZE*8  write data
core_req_tag  in  TAG_WIDTH  request tag
core_req_ready  out  1  request accepted when valid&ready
core_rsp_valid  out  1  read response valid
core_rsp_data  out  DATA_SIZE*8  read data
core_rsp_tag  out  TAG_WIDTH  tag of the matching read
core_rsp_ready  in  1  core accepts response
mem_req_valid  out  1  external request valid
mem_req_rw  out  1  write enable
mem_req_addr  out  EXT_ADDR_WIDTH  core_req_addr[EXT_ADDR_WIDTH-1:0]
mem_req_byteen  out  DATA_SIZE  byte enables
mem_req_data  out  DATA_SIZE*8  write data
mem_req_ready  in  1  external accepts request
mem_rsp_valid  in  1  read data returning, in request order, no backpressure
mem_rsp_data  in  DATA_SIZE*8  read data
pending_count  out  clog2(MAX_PENDING)+1  reads accepted but not yet delivered to core
err_unexpected_rsp  out  1  sticky: mem_rsp_valid with empty tag FIFO
err_addr_range  out  1  sticky: accepted request with nonzero core_req_addr bits above EXT_ADDR_WIDTH

Behaviour:
- Reset (reset=0, async): all outputs 0; request register, tag FIFO, response FIFO emptied; pending_count=0; error flags cleared. In-flight traffic is dropped; responses arriving after reset deassertion set err_unexpected_rsp.
- Request stage: single output register (req_full).
- core_req_ready = (!req_full || mem_req_ready) && (core_req_rw || pending_count < MAX_PENDING).
- Accept in cycle N → mem_req_valid=1 in cycle N+1, fields held stable until mem_req_ready.
- Back-to-back accepts are allowed when mem_req_ready=1 every cycle (full throughput).
- Read accept: push core_req_tag to the tag FIFO; pending_count +1.
- Write accept: no tag push, no response ever generated.
- mem_rsp_valid in cycle M: pop the tag FIFO head; push {data, tag} into the response FIFO.
- core_rsp_valid is asserted in M+1 if the FIFO was empty (registered FIFO output, no bypass).
- core_rsp_* = response FIFO head; pop on core_rsp_valid & core_rsp_ready; pending_count −1.
- Same-cycle read accept and core response pop: pending_count unchanged.
- pending_count counts tag FIFO plus response FIFO occupancy. The credit check guarantees the response FIFO never overflows despite no mem backpressure.
- mem_rsp_valid with empty tag FIFO: drop data, set err_unexpected_rsp (sticky until reset).
- Responses are strictly in order; tags are opaque and duplicate tags are legal.
- err_addr_range is set on accept (read or write) when core_req_addr[ADDR_WIDTH-1:EXT_ADDR_WIDTH] != 0. The request is still forwarded with the truncated address.
- Writes are not blocked by pending_count = MAX_PENDING; reads are.

Test Plan:
- Single read addr 0x10 tag 0x5A: accept at cycle 0 → mem_req_valid cycle 1 addr 0x010 rw 0. mem_rsp data 0xDEADBEEF at cycle 3 → core_rsp cycle 4 data 0xDEADBEEF tag 0x5A; pending_count 1→0 after handshake.
- 4 reads back-to-back (tags 1..4), core_rsp_ready=0: 5th read stalls with core_req_ready=0 and pending_count=4. A write issued meanwhile is accepted. Raising rsp_ready drains tags 1,2,3,4 in order; the 5th read then accepts.
- mem_req_ready held 0 for 3 cycles: mem_req fields stay stable; core_req_ready=0 once req_full; no request is lost or duplicated.
- Write byteen 4'b0011 data 0x1234ABCD: forwarded unchanged; no core_rsp ever; pending_count stays 0.
- mem_rsp_valid pulse with no outstanding read → err_unexpected_rsp=1 and stays 1; core_rsp_valid stays 0.
- Read addr 0x1000 (EXT_ADDR_WIDTH=12): mem_req_addr=0x000, err_addr_range=1. Assert reset mid-burst with 2 pending → all outputs 0, pending_count=0, flags cleared.
